act_lane_arbiter: RTL and testbench

- Round-robin arbiter that shares one bit converter FIFO block among NUM_LANES activation lanes.
- Each lane presents 8-bit activation values with a valid/ack handshake. The arbiter forwards the values one per cycle into the converter's values FIFO write port (data / enable / ready) and emits a lane tag with each write.
- A lane may keep the grant for a bounded burst of consecutive values, which limits grant switching without starving the other lanes.

---
 rtl/act_lane_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_act_lane_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_lane_arbiter.sv
// act_lane_arbiter
//   Round-robin arbiter that shares one bit-converter values FIFO write port
//   among NUM_LANES activation lanes. The granted lane may hold the grant for
//   up to BURST_MAX consecutive values before the pointer moves on.
//
// Ports
//   CLK                    clock, rising edge
//   RSTN                   synchronous active-low reset
//   LaneValid[N]           lane i has a value pending
//   LaneData[8N]           lane i value in bits [8i+7:8i]
//   LaneAck[N]             combinational; lane i's value is consumed this edge
//   ValuesFIFOWriteReady   converter FIFO can accept a write
//   ValuesFIFOWriteEnable  registered one-cycle write strobe
//   ValuesFIFOWriteDataIn  registered value being written
//   LaneTagOut             registered lane index of the written value
//   Busy                   registered; high while a burst is in progress
//   DropCount              registered saturating count of skipped zero values
//
// Build option
//   ARB_ZERO_SKIP_EN  when defined, granted 8'h00 values are acked without being
//                     written (even under backpressure) and counted in
//                     DropCount. When undefined, zeros are forwarded normally
//                     and DropCount stays 0.
//
// States
//   s_idle  | no lane holds the grant; search from ptr for the next valid lane
//   s_burst | lane ptr holds the grant until BURST_MAX values or valid drops

module act_lane_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2,
  parameter int BURST_MAX = 4
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [NUM_LANES-1:0]   LaneValid,
  input  logic [8*NUM_LANES-1:0] LaneData,
  output logic [NUM_LANES-1:0]   LaneAck,
  input  logic                   ValuesFIFOWriteReady,
  output logic                   ValuesFIFOWriteEnable,
  output logic [7:0]             ValuesFIFOWriteDataIn,
  output logic [LANE_W-1:0]      LaneTagOut,
  output logic                   Busy,
  output logic [15:0]            DropCount
);

  typedef enum logic {s_idle, s_burst} stateT;

  localparam logic [7:0]        BURST_LIM = 8'(BURST_MAX);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [LANE_W:0]   LANES_W   = (LANE_W + 1)'(NUM_LANES);

  stateT             state, stateNext;
  logic [LANE_W-1:0] ptr, ptrNext, ptrInc;
  logic [LANE_W-1:0] grant, grantInc, searchIdx;
  logic [LANE_W:0]   idxWide;
  logic [7:0]        cnt, cntNext, cntInc, grantData;
  logic              searchHit, grantValid, doWrite, doSkip, doAck;

  // Rotating-priority search starting at ptr; indices wrap modulo NUM_LANES,
  // which also works when NUM_LANES is not a power of two.
  always_comb begin
    searchHit = 1'b0;
    searchIdx = '0;
    idxWide   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idxWide = {1'b0, ptr} + (LANE_W + 1)'(k);
      if (idxWide >= LANES_W) idxWide = idxWide - LANES_W;
      if (!searchHit && LaneValid[idxWide[LANE_W-1:0]]) begin
        searchHit = 1'b1;
        searchIdx = idxWide[LANE_W-1:0];
      end
    end
  end

  always_comb begin
    grant      = (state == s_burst) ? ptr : searchIdx;
    grantValid = LaneValid[grant];
    grantData  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (grant == LANE_W'(i)) grantData = LaneData[8*i +: 8];
    end
  end

  assign ptrInc   = (ptr == LAST_LANE) ? '0 : ptr + 1'b1;
  assign grantInc = (grant == LAST_LANE) ? '0 : grant + 1'b1;

`ifdef ARB_ZERO_SKIP_EN
  // A zero value produces no bit places, so it is consumed without a write
  // and without waiting for the FIFO.
  assign doSkip = RSTN && grantValid && (grantData == 8'h00);
`else
  assign doSkip = 1'b0;
`endif

  // Gating with RSTN keeps lanes from losing a value during a reset cycle.
  assign doWrite = RSTN && grantValid && ValuesFIFOWriteReady && !doSkip;
  assign doAck   = doWrite || doSkip;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      LaneAck[i] = doAck && (grant == LANE_W'(i));
    end
  end

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    cntNext   = cnt;
    cntInc    = cnt + 8'd1;
    unique case (state)
      s_idle: begin
        if (doWrite) begin
          cntNext = 8'd1;
          if (BURST_MAX == 1) begin
            ptrNext = grantInc;
          end else begin
            ptrNext   = grant;
            stateNext = s_burst;
          end
        end else if (doSkip) begin
          // Skipped zero holds the grant but does not use up burst budget.
          cntNext   = '0;
          ptrNext   = grant;
          stateNext = s_burst;
        end
      end
      s_burst: begin
        if (!grantValid) begin
          ptrNext   = ptrInc;
          cntNext   = '0;
          stateNext = s_idle;
        end else if (doWrite) begin
          if (cntInc == BURST_LIM) begin
            ptrNext   = ptrInc;
            cntNext   = '0;
            stateNext = s_idle;
          end else begin
            cntNext = cntInc;
          end
        end
      end
      default: stateNext = s_idle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state                 <= s_idle;
      ptr                   <= '0;
      cnt                   <= '0;
      ValuesFIFOWriteEnable <= 1'b0;
      ValuesFIFOWriteDataIn <= '0;
      LaneTagOut            <= '0;
      Busy                  <= 1'b0;
    end else begin
      state                 <= stateNext;
      ptr                   <= ptrNext;
      cnt                   <= cntNext;
      ValuesFIFOWriteEnable <= doWrite;
      if (doWrite) begin
        ValuesFIFOWriteDataIn <= grantData;
        LaneTagOut            <= grant;
      end
      Busy <= (stateNext == s_burst);
    end
  end

`ifdef ARB_ZERO_SKIP_EN
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      DropCount <= '0;
    end else if (doSkip && (DropCount != 16'hFFFF)) begin
      DropCount <= DropCount + 16'd1;
    end
  end
`else
  assign DropCount = '0;
`endif

endmodule

// File: tb/tb_act_lane_arbiter.sv
module tb_act_lane_arbiter;
  localparam int N  = 4;
  localparam int LW = 2;
  localparam int BM = 4;

  logic           CLK = 1'b0;
  logic           RSTN = 1'b0;
  logic [N-1:0]   LaneValid = '0;
  logic [8*N-1:0] LaneData = '0;
  logic [N-1:0]   LaneAck;
  logic           ValuesFIFOWriteReady = 1'b0;
  logic           ValuesFIFOWriteEnable;
  logic [7:0]     ValuesFIFOWriteDataIn;
  logic [LW-1:0]  LaneTagOut;
  logic           Busy;
  logic [15:0]    DropCount;

  act_lane_arbiter #(.NUM_LANES(N), .LANE_W(LW), .BURST_MAX(BM)) dut (
    .CLK(CLK), .RSTN(RSTN), .LaneValid(LaneValid), .LaneData(LaneData),
    .LaneAck(LaneAck), .ValuesFIFOWriteReady(ValuesFIFOWriteReady),
    .ValuesFIFOWriteEnable(ValuesFIFOWriteEnable),
    .ValuesFIFOWriteDataIn(ValuesFIFOWriteDataIn), .LaneTagOut(LaneTagOut),
    .Busy(Busy), .DropCount(DropCount)
  );

  always #5 CLK = ~CLK;

  // lane sources
  logic [7:0] vals [N][16];
  int         cntv [N];
  int         seq  [N];

  // reference model and scoreboard
  logic       mBurst, expWe, mWrite, mSkip;
  int         mPtr, mCnt, mG, expDrop;
  logic [7:0] mData;
  logic [N-1:0] expAck;
  logic [9:0] expQ [$];
  logic [9:0] got, expE;

  int vectors = 0;
  int miscompares = 0;

  task automatic clearLanes();
    for (int i = 0; i < N; i++) begin
      cntv[i] = 0;
      seq[i]  = 0;
      for (int j = 0; j < 16; j++) vals[i][j] = 8'h00;
    end
  endtask

  task automatic driveLanes();
    for (int i = 0; i < N; i++) begin
      if (seq[i] < cntv[i]) begin
        LaneValid[i] = 1'b1;
        LaneData[8*i +: 8] = vals[i][seq[i]];
      end else begin
        LaneValid[i] = 1'b0;
        LaneData[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task automatic modelComb();
    logic found;
    logic [1:0] gi;
    found = 1'b0;
    mG = mPtr;
    if (!mBurst) begin
      for (int k = 0; k < N; k++) begin
        if (!found && LaneValid[2'((mPtr + k) % N)]) begin
          found = 1'b1;
          mG = (mPtr + k) % N;
        end
      end
    end
    gi = 2'(mG);
    mData = 8'h00;
    for (int i = 0; i < N; i++) if (i == mG) mData = LaneData[8*i +: 8];
    mSkip = 1'b0;
`ifdef ARB_ZERO_SKIP_EN
    mSkip = RSTN && LaneValid[gi] && (mData == 8'h00);
`endif
    mWrite = RSTN && LaneValid[gi] && ValuesFIFOWriteReady && !mSkip;
    expAck = '0;
    if (mWrite || mSkip) expAck[gi] = 1'b1;
  endtask

  task automatic modelEdge();
    if (!RSTN) begin
      mBurst = 1'b0; mPtr = 0; mCnt = 0; expWe = 1'b0; expDrop = 0;
    end else begin
      expWe = mWrite;
      if (mWrite) expQ.push_back({2'(mG), mData});
      if (mSkip && expDrop < 65535) expDrop++;
      if (mWrite || mSkip) seq[mG]++;
      if (!mBurst) begin
        if (mWrite) begin
          mCnt = 1;
          if (BM == 1) mPtr = (mG + 1) % N;
          else begin mPtr = mG; mBurst = 1'b1; end
        end else if (mSkip) begin
          mCnt = 0; mPtr = mG; mBurst = 1'b1;
        end
      end else if (!LaneValid[2'(mPtr)]) begin
        mPtr = (mPtr + 1) % N; mCnt = 0; mBurst = 1'b0;
      end else if (mWrite) begin
        if (mCnt + 1 == BM) begin
          mPtr = (mPtr + 1) % N; mCnt = 0; mBurst = 1'b0;
        end else begin
          mCnt++;
        end
      end
    end
  endtask

  task automatic applyReset();
    RSTN = 1'b0;
    ValuesFIFOWriteReady = 1'b0;
    LaneValid = '0;
    LaneData = '0;
    @(posedge CLK);
    modelEdge();
    #1;
    RSTN = 1'b1;
    expQ.delete();
  endtask

  task automatic test_reset();
    clearLanes();
    applyReset();
    driveLanes();
    @(negedge CLK);
    modelComb();
    vectors++; if (ValuesFIFOWriteEnable !== 1'b0) begin miscompares++; $display("FAIL reset strobe got=%b want=0", ValuesFIFOWriteEnable); end
    vectors++; if (ValuesFIFOWriteDataIn !== 8'h00) begin miscompares++; $display("FAIL reset data got=%h want=00", ValuesFIFOWriteDataIn); end
    vectors++; if (LaneTagOut !== 2'd0) begin miscompares++; $display("FAIL reset tag got=%0d want=0", LaneTagOut); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got=%b want=0", Busy); end
    vectors++; if (DropCount !== 16'h0000) begin miscompares++; $display("FAIL reset dropcount got=%h want=0000", DropCount); end
    vectors++; if (LaneAck !== 4'b0000) begin miscompares++; $display("FAIL reset ack got=%b want=0000", LaneAck); end
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  task automatic test_single_lane();
    clearLanes();
    applyReset();
    cntv[2] = 3; vals[2][0] = 8'hA5; vals[2][1] = 8'hA6; vals[2][2] = 8'hA7;
    for (int c = 0; c < 7; c++) begin
      ValuesFIFOWriteReady = 1'b1;
      driveLanes();
      @(negedge CLK);
      modelComb();
      vectors++; if (LaneAck !== expAck) begin miscompares++; $display("FAIL single ack c=%0d got=%b want=%b", c, LaneAck, expAck); end
      vectors++; if (ValuesFIFOWriteEnable !== expWe) begin miscompares++; $display("FAIL single strobe c=%0d got=%b want=%b", c, ValuesFIFOWriteEnable, expWe); end
      if (ValuesFIFOWriteEnable === 1'b1) begin
        vectors++; got = {LaneTagOut, ValuesFIFOWriteDataIn};
        if (expQ.size() == 0) begin miscompares++; $display("FAIL single write c=%0d got=%h want=none", c, got); end
        else begin expE = expQ.pop_front(); if (got !== expE) begin miscompares++; $display("FAIL single write c=%0d got=%h want=%h", c, got, expE); end end
      end
      vectors++; if (Busy !== mBurst) begin miscompares++; $display("FAIL single busy c=%0d got=%b want=%b", c, Busy, mBurst); end
      if (c == 0) begin vectors++; if (LaneAck !== 4'b0100) begin miscompares++; $display("FAIL single first_ack got=%b want=0100", LaneAck); end end
      if (c == 1) begin vectors++; if ({LaneTagOut, ValuesFIFOWriteDataIn} !== {2'd2, 8'hA5}) begin miscompares++; $display("FAIL single first_write got=%0d/%h want=2/a5", LaneTagOut, ValuesFIFOWriteDataIn); end end
      @(posedge CLK); modelEdge(); #1;
    end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("FAIL single pending got=%0d want=0", expQ.size()); end
  endtask

  task automatic test_round_robin();
    int nStrobe;
    clearLanes();
    applyReset();
    nStrobe = 0;
    for (int i = 0; i < N; i++) begin
      cntv[i] = (i == 0) ? 8 : 4;
      for (int j = 0; j < 8; j++) vals[i][j] = 8'((i + 1) * 16 + j);
    end
    for (int c = 0; c < 23; c++) begin
      ValuesFIFOWriteReady = 1'b1;
      driveLanes();
      @(negedge CLK);
      modelComb();
      vectors++; if (LaneAck !== expAck) begin miscompares++; $display("FAIL rr ack c=%0d got=%b want=%b", c, LaneAck, expAck); end
      vectors++; if ($countones(LaneAck) > 1) begin miscompares++; $display("FAIL rr onehot c=%0d got=%b want=at most one", c, LaneAck); end
      vectors++; if (ValuesFIFOWriteEnable !== expWe) begin miscompares++; $display("FAIL rr strobe c=%0d got=%b want=%b", c, ValuesFIFOWriteEnable, expWe); end
      if (ValuesFIFOWriteEnable === 1'b1) begin
        vectors++; got = {LaneTagOut, ValuesFIFOWriteDataIn};
        if (expQ.size() == 0) begin miscompares++; $display("FAIL rr write c=%0d got=%h want=none", c, got); end
        else begin expE = expQ.pop_front(); if (got !== expE) begin miscompares++; $display("FAIL rr write c=%0d got=%h want=%h", c, got, expE); end end
        if (nStrobe < 20) begin
          vectors++; if (LaneTagOut !== 2'((nStrobe / 4) % 4)) begin miscompares++; $display("FAIL rr tagseq n=%0d got=%0d want=%0d", nStrobe, LaneTagOut, (nStrobe / 4) % 4); end
        end
        nStrobe++;
      end
      vectors++; if (Busy !== mBurst) begin miscompares++; $display("FAIL rr busy c=%0d got=%b want=%b", c, Busy, mBurst); end
      @(posedge CLK); modelEdge(); #1;
    end
    vectors++; if (nStrobe != 20) begin miscompares++; $display("FAIL rr strobes got=%0d want=20", nStrobe); end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("FAIL rr pending got=%0d want=0", expQ.size()); end
  endtask

  task automatic test_backpressure();
    clearLanes();
    applyReset();
    cntv[1] = 6;
    for (int j = 0; j < 6; j++) vals[1][j] = 8'h40 + 8'(j);
    for (int c = 0; c < 12; c++) begin
      ValuesFIFOWriteReady = !(c >= 2 && c <= 4);
      driveLanes();
      @(negedge CLK);
      modelComb();
      vectors++; if (LaneAck !== expAck) begin miscompares++; $display("FAIL bp ack c=%0d got=%b want=%b", c, LaneAck, expAck); end
      vectors++; if (ValuesFIFOWriteEnable !== expWe) begin miscompares++; $display("FAIL bp strobe c=%0d got=%b want=%b", c, ValuesFIFOWriteEnable, expWe); end
      if (ValuesFIFOWriteEnable === 1'b1) begin
        vectors++; got = {LaneTagOut, ValuesFIFOWriteDataIn};
        if (expQ.size() == 0) begin miscompares++; $display("FAIL bp write c=%0d got=%h want=none", c, got); end
        else begin expE = expQ.pop_front(); if (got !== expE) begin miscompares++; $display("FAIL bp write c=%0d got=%h want=%h", c, got, expE); end end
      end
      vectors++; if (Busy !== mBurst) begin miscompares++; $display("FAIL bp busy c=%0d got=%b want=%b", c, Busy, mBurst); end
      if (c >= 2 && c <= 4) begin vectors++; if (LaneAck !== 4'b0000) begin miscompares++; $display("FAIL bp stall_ack c=%0d got=%b want=0000", c, LaneAck); end end
      @(posedge CLK); modelEdge(); #1;
    end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("FAIL bp pending got=%0d want=0", expQ.size()); end
  endtask

  task automatic test_early_release();
    clearLanes();
    applyReset();
    cntv[0] = 2; vals[0][0] = 8'h51; vals[0][1] = 8'h52;
    cntv[3] = 3; vals[3][0] = 8'h71; vals[3][1] = 8'h72; vals[3][2] = 8'h73;
    for (int c = 0; c < 9; c++) begin
      ValuesFIFOWriteReady = 1'b1;
      driveLanes();
      @(negedge CLK);
      modelComb();
      vectors++; if (LaneAck !== expAck) begin miscompares++; $display("FAIL early ack c=%0d got=%b want=%b", c, LaneAck, expAck); end
      vectors++; if (ValuesFIFOWriteEnable !== expWe) begin miscompares++; $display("FAIL early strobe c=%0d got=%b want=%b", c, ValuesFIFOWriteEnable, expWe); end
      if (ValuesFIFOWriteEnable === 1'b1) begin
        vectors++; got = {LaneTagOut, ValuesFIFOWriteDataIn};
        if (expQ.size() == 0) begin miscompares++; $display("FAIL early write c=%0d got=%h want=none", c, got); end
        else begin expE = expQ.pop_front(); if (got !== expE) begin miscompares++; $display("FAIL early write c=%0d got=%h want=%h", c, got, expE); end end
      end
      vectors++; if (Busy !== mBurst) begin miscompares++; $display("FAIL early busy c=%0d got=%b want=%b", c, Busy, mBurst); end
      if (c == 2) begin vectors++; if (LaneAck !== 4'b0000) begin miscompares++; $display("FAIL early bubble got=%b want=0000", LaneAck); end end
      if (c == 3) begin vectors++; if (LaneAck !== 4'b1000) begin miscompares++; $display("FAIL early regrant got=%b want=1000", LaneAck); end end
      @(posedge CLK); modelEdge(); #1;
    end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("FAIL early pending got=%0d want=0", expQ.size()); end
  endtask

  task automatic test_reset_mid_burst();
    clearLanes();
    applyReset();
    cntv[2] = 8; cntv[3] = 4;
    for (int j = 0; j < 8; j++) begin vals[2][j] = 8'h80 + 8'(j); vals[3][j] = 8'hC0 + 8'(j); end
    for (int c = 0; c < 18; c++) begin
      RSTN = (c != 2);
      ValuesFIFOWriteReady = 1'b1;
      driveLanes();
      @(negedge CLK);
      modelComb();
      vectors++; if (LaneAck !== expAck) begin miscompares++; $display("FAIL midrst ack c=%0d got=%b want=%b", c, LaneAck, expAck); end
      vectors++; if (ValuesFIFOWriteEnable !== expWe) begin miscompares++; $display("FAIL midrst strobe c=%0d got=%b want=%b", c, ValuesFIFOWriteEnable, expWe); end
      if (ValuesFIFOWriteEnable === 1'b1) begin
        vectors++; got = {LaneTagOut, ValuesFIFOWriteDataIn};
        if (expQ.size() == 0) begin miscompares++; $display("FAIL midrst write c=%0d got=%h want=none", c, got); end
        else begin expE = expQ.pop_front(); if (got !== expE) begin miscompares++; $display("FAIL midrst write c=%0d got=%h want=%h", c, got, expE); end end
      end
      vectors++; if (Busy !== mBurst) begin miscompares++; $display("FAIL midrst busy c=%0d got=%b want=%b", c, Busy, mBurst); end
      if (c == 3) begin
        vectors++; if ({LaneTagOut, ValuesFIFOWriteDataIn} !== 10'h000) begin miscompares++; $display("FAIL midrst cleared got=%0d/%h want=0/00", LaneTagOut, ValuesFIFOWriteDataIn); end
        vectors++; if (LaneAck !== 4'b0100) begin miscompares++; $display("FAIL midrst regrant got=%b want=0100", LaneAck); end
      end
      @(posedge CLK); modelEdge(); #1;
    end
    RSTN = 1'b1;
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("FAIL midrst pending got=%0d want=0", expQ.size()); end
  endtask

  task automatic test_zero_values();
    clearLanes();
    applyReset();
    cntv[0] = 3; vals[0][0] = 8'h00; vals[0][1] = 8'h00; vals[0][2] = 8'h03;
    for (int c = 0; c < 8; c++) begin
      ValuesFIFOWriteReady = (c >= 2);
      driveLanes();
      @(negedge CLK);
      modelComb();
      vectors++; if (LaneAck !== expAck) begin miscompares++; $display("FAIL zero ack c=%0d got=%b want=%b", c, LaneAck, expAck); end
      vectors++; if (ValuesFIFOWriteEnable !== expWe) begin miscompares++; $display("FAIL zero strobe c=%0d got=%b want=%b", c, ValuesFIFOWriteEnable, expWe); end
      if (ValuesFIFOWriteEnable === 1'b1) begin
        vectors++; got = {LaneTagOut, ValuesFIFOWriteDataIn};
        if (expQ.size() == 0) begin miscompares++; $display("FAIL zero write c=%0d got=%h want=none", c, got); end
        else begin expE = expQ.pop_front(); if (got !== expE) begin miscompares++; $display("FAIL zero write c=%0d got=%h want=%h", c, got, expE); end end
      end
      vectors++; if (DropCount !== 16'(expDrop)) begin miscompares++; $display("FAIL zero dropcount c=%0d got=%0d want=%0d", c, DropCount, expDrop); end
      vectors++; if (Busy !== mBurst) begin miscompares++; $display("FAIL zero busy c=%0d got=%b want=%b", c, Busy, mBurst); end
`ifdef ARB_ZERO_SKIP_EN
      if (c == 2) begin vectors++; if (DropCount !== 16'd2) begin miscompares++; $display("FAIL zero skipped got=%0d want=2", DropCount); end end
      if (c == 3) begin vectors++; if ({ValuesFIFOWriteEnable, ValuesFIFOWriteDataIn} !== {1'b1, 8'h03}) begin miscompares++; $display("FAIL zero forward got=%b/%h want=1/03", ValuesFIFOWriteEnable, ValuesFIFOWriteDataIn); end end
`else
      if (c == 2) begin vectors++; if (LaneAck !== 4'b0001) begin miscompares++; $display("FAIL zero passthru got=%b want=0001", LaneAck); end end
`endif
      @(posedge CLK); modelEdge(); #1;
    end
    vectors++; if (expQ.size() != 0) begin miscompares++; $display("FAIL zero pending got=%0d want=0", expQ.size()); end
  endtask

  initial begin
    mBurst = 1'b0; mPtr = 0; mCnt = 0; mG = 0; expDrop = 0;
    expWe = 1'b0; mWrite = 1'b0; mSkip = 1'b0; mData = 8'h00; expAck = '0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_zero_values();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
